// File: rtl/thermostat_pkg.sv
// Shared definitions for the thermostat SPI request path: scheduler state
// encoding, SPI temperature width, default timing constants and a helper
// that sizes counters.
package thermostat_pkg;

    // Raw temperature width delivered by the SPI handler.
    localparam int c_spi_temp_w = 10;

    // Default timing at the 20 kHz system clock.
    localparam int c_poll_period_dflt = 10000;  // 0.5 s between thermometer polls
    localparam int c_timeout_dflt     = 4000;   // 0.2 s allowed for a ready
    localparam int c_fault_limit_dflt = 3;      // consecutive therm timeouts to flag a fault

    // Scheduler states.
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_THERM_WAIT = 2'd1,
        S_PROG_WAIT  = 2'd2,
        S_RELEASE    = 2'd3
    } sched_state_t;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sched_interval_timer.sv
// Free-running interval timer: counts 0..g_period-1 and flags the terminal
// count for one clock every period. Used as the thermometer poll tick.
module sched_interval_timer
    import thermostat_pkg::*;
#(
    parameter int g_period = c_poll_period_dflt
)(
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int              c_w    = cnt_width(g_period);
    localparam logic [c_w-1:0]  c_last = c_w'(g_period - 1);

    logic [c_w-1:0] r_count;

    // Period counter, wrapping to zero after the terminal count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_w'(1);
        end
    end

    // Terminal-count decode of the counter register; high for one clock per period.
    assign o_tick = (r_count == c_last);

endmodule

// File: rtl/spi_request_scheduler.sv
// Arbitrates the shared SPI handler between the periodic thermometer poll
// and one-shot schedule-program loads. Requests are levels held until the
// matching ready (or a watchdog timeout), followed by a RELEASE state that
// waits for the handler to drop its ready before any new request, so the
// two requests are never high together. Good temperature readings are
// captured for the thermostat controller; repeated therm timeouts raise a
// sticky fault that the next good reading clears.
module spi_request_scheduler
    import thermostat_pkg::*;
#(
    parameter int g_poll_period = c_poll_period_dflt,
    parameter int g_timeout     = c_timeout_dflt,
    parameter int g_fault_limit = c_fault_limit_dflt
)(
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_prog_load_req,
    output logic                    o_prog_busy,
    output logic                    o_prog_done,
    output logic                    o_prog_err,
    output logic                    o_read_therm,
    input  logic                    i_therm_ready,
    input  logic [c_spi_temp_w-1:0] i_spi_temp,
    output logic                    o_read_program,
    input  logic                    i_program_ready,
    output logic [c_spi_temp_w-1:0] o_temperature,
    output logic                    o_temp_update,
    output logic                    o_temp_valid,
    output logic                    o_spi_fault
);

    // Watchdog spans 0..g_timeout-1; fault counter saturates at g_fault_limit.
    localparam int                 c_wd_w    = cnt_width(g_timeout);
    localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(g_timeout - 1);
    localparam int                 c_fc_w    = cnt_width(g_fault_limit + 1);
    localparam logic [c_fc_w-1:0]  c_fc_lim  = c_fc_w'(g_fault_limit);
    localparam logic [c_fc_w-1:0]  c_fc_trip = c_fc_w'(g_fault_limit - 1);

    sched_state_t               r_state;
    logic                       r_therm_pend;
    logic                       r_prog_pend;
    logic                       r_prog_busy;
    logic                       r_rel_prog;     // current RELEASE follows a program load
    logic [c_wd_w-1:0]          r_watchdog;
    logic [c_fc_w-1:0]          r_fault_cnt;
    logic                       r_read_therm;
    logic                       r_read_program;
    logic [c_spi_temp_w-1:0]    r_temperature;
    logic                       r_temp_update;
    logic                       r_temp_valid;
    logic                       r_spi_fault;
    logic                       r_prog_done;
    logic                       r_prog_err;

    logic                       w_tick;
    logic                       w_wd_expired;
    logic                       w_prog_accept;
    logic                       w_take_therm;
    logic                       w_take_prog;
    logic                       w_release_done;

    sched_interval_timer #(
        .g_period (g_poll_period)
    ) u_poll_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_tick    (w_tick)
    );

    // Decode of arbitration, watchdog expiry and release completion.
    always_comb begin
        w_wd_expired   = 1'b0;
        w_prog_accept  = 1'b0;
        w_take_therm   = 1'b0;
        w_take_prog    = 1'b0;
        w_release_done = 1'b0;
        w_wd_expired   = (r_watchdog == c_wd_last);
        // A load request is only accepted when no load is pending or running.
        w_prog_accept  = i_prog_load_req & ~r_prog_busy;
        if (r_state == S_IDLE) begin
            // Thermometer wins when both are pending in the same cycle.
            w_take_therm = r_therm_pend;
            w_take_prog  = ~r_therm_pend & r_prog_pend;
        end else begin
            w_take_therm = 1'b0;
            w_take_prog  = 1'b0;
        end
        if (r_state == S_RELEASE) begin
            w_release_done = (~i_therm_ready & ~i_program_ready) | w_wd_expired;
        end else begin
            w_release_done = 1'b0;
        end
    end

    // Pending flags: poll ticks arriving while therm is already pending merge into one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_therm_pend <= 1'b0;
            r_prog_pend  <= 1'b0;
        end else begin
            r_therm_pend <= w_tick | (r_therm_pend & ~w_take_therm);
            r_prog_pend  <= w_prog_accept | (r_prog_pend & ~w_take_prog);
        end
    end

    // Program-busy covers pending, PROG_WAIT and the RELEASE that follows a load.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prog_busy <= 1'b0;
        end else begin
            r_prog_busy <= w_prog_accept | (r_prog_busy & ~(w_release_done & r_rel_prog));
        end
    end

    // Request sequencer with inline watchdog, temperature capture and fault tracking.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_read_therm   <= 1'b0;
            r_read_program <= 1'b0;
            r_watchdog     <= '0;
            r_rel_prog     <= 1'b0;
            r_temperature  <= '0;
            r_temp_update  <= 1'b0;
            r_temp_valid   <= 1'b0;
            r_fault_cnt    <= '0;
            r_spi_fault    <= 1'b0;
            r_prog_done    <= 1'b0;
            r_prog_err     <= 1'b0;
        end else begin
            // Event outputs are single-clock pulses unless re-raised below.
            r_temp_update <= 1'b0;
            r_prog_done   <= 1'b0;
            r_prog_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_watchdog <= '0;
                    if (r_therm_pend) begin
                        r_state      <= S_THERM_WAIT;
                        r_read_therm <= 1'b1;
                    end else if (r_prog_pend) begin
                        r_state        <= S_PROG_WAIT;
                        r_read_program <= 1'b1;
                    end else begin
                        r_read_therm   <= 1'b0;
                        r_read_program <= 1'b0;
                    end
                end
                S_THERM_WAIT: begin
                    if (i_therm_ready) begin
                        r_temperature <= i_spi_temp;
                        r_temp_update <= 1'b1;
                        r_temp_valid  <= 1'b1;
                        r_fault_cnt   <= '0;
                        r_spi_fault   <= 1'b0;
                        r_read_therm  <= 1'b0;
                        r_rel_prog    <= 1'b0;
                        r_watchdog    <= '0;
                        r_state       <= S_RELEASE;
                    end else if (w_wd_expired) begin
                        // Timeout: last good temperature is kept as is.
                        if (r_fault_cnt != c_fc_lim) begin
                            r_fault_cnt <= r_fault_cnt + c_fc_w'(1);
                        end else begin
                            r_fault_cnt <= r_fault_cnt;
                        end
                        if (r_fault_cnt >= c_fc_trip) begin
                            r_spi_fault <= 1'b1;
                        end else begin
                            r_spi_fault <= r_spi_fault;
                        end
                        r_read_therm <= 1'b0;
                        r_rel_prog   <= 1'b0;
                        r_watchdog   <= '0;
                        r_state      <= S_RELEASE;
                    end else begin
                        r_watchdog <= r_watchdog + c_wd_w'(1);
                    end
                end
                S_PROG_WAIT: begin
                    if (i_program_ready || w_wd_expired) begin
                        r_prog_done    <= i_program_ready;
                        r_prog_err     <= ~i_program_ready;
                        r_read_program <= 1'b0;
                        r_rel_prog     <= 1'b1;
                        r_watchdog     <= '0;
                        r_state        <= S_RELEASE;
                    end else begin
                        r_watchdog <= r_watchdog + c_wd_w'(1);
                    end
                end
                S_RELEASE: begin
                    r_read_therm   <= 1'b0;
                    r_read_program <= 1'b0;
                    if (w_release_done) begin
                        r_rel_prog <= 1'b0;
                        r_watchdog <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_watchdog <= r_watchdog + c_wd_w'(1);
                    end
                end
                default: begin
                    r_read_therm   <= 1'b0;
                    r_read_program <= 1'b0;
                    r_rel_prog     <= 1'b0;
                    r_watchdog     <= '0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign o_prog_busy    = r_prog_busy;
    assign o_prog_done    = r_prog_done;
    assign o_prog_err     = r_prog_err;
    assign o_read_therm   = r_read_therm;
    assign o_read_program = r_read_program;
    assign o_temperature  = r_temperature;
    assign o_temp_update  = r_temp_update;
    assign o_temp_valid   = r_temp_valid;
    assign o_spi_fault    = r_spi_fault;

endmodule
